// File: rtl/pc_fetch.sv
// Instruction fetch unit: PC sequencing, redirect handling and imem request FSM.
// Optional `PC_ALIGN_CHECK_EN builds a sticky misaligned register-target flag.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [1:0]  Jump_sel,
   input  logic [31:0] br_pc4,
   input  logic [15:0] br_imm,
   input  logic [25:0] j_target,
   input  logic [31:0] rs_val,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc4,
   output logic        if_valid,
   output logic        flush,
   output logic        misalign_err
);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

   state_t      state_q;
   logic        req_q;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic [31:0] instr_q;
   logic [31:0] pc4_q;
   logic        valid_q;

   logic        redir;
   logic        xfer;
   logic [31:0] target_d;
   logic [31:0] next_pc_d;

   assign redir = (Jump_sel != 2'b00) && !stall;
   assign xfer  = req_q && imem_ready;

   always_comb begin
      target_d = pc_q;
      case (Jump_sel)
         2'b01:   target_d = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
         2'b10:   target_d = {br_pc4[31:28], j_target, 2'b00};
         2'b11:   target_d = rs_val & 32'hFFFF_FFFC;
         default: target_d = pc_q;
      endcase
   end

   assign next_pc_d = redir ? target_d : pc_q;

   // Outstanding request in DRAIN keeps its old address; pc_q holds the pending target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         instr_q <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               req_q   <= 1'b1;
               pc_q    <= next_pc_d;
               addr_q  <= next_pc_d;
            end
            REQ: begin
               if (redir) begin
                  pc_q    <= target_d;
                  valid_q <= 1'b0;
                  if (xfer) begin
                     addr_q <= target_d;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else if (xfer) begin
                  instr_q <= imem_rdata;
                  pc4_q   <= addr_q + 32'd4;
                  valid_q <= 1'b1;
                  pc_q    <= pc_q + 32'd4;
                  addr_q  <= pc_q + 32'd4;
                  if (stall) begin
                     state_q <= HOLD;
                     req_q   <= 1'b0;
                  end
               end else if (!stall) begin
                  valid_q <= 1'b0;
               end
            end
            DRAIN: begin
               pc_q <= next_pc_d;
               if (redir) begin
                  valid_q <= 1'b0;
               end
               if (xfer) begin
                  state_q <= REQ;
                  addr_q  <= next_pc_d;
               end
            end
            HOLD: begin
               if (!stall) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
                  valid_q <= 1'b0;
                  pc_q    <= next_pc_d;
                  addr_q  <= next_pc_d;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else if (redir && (Jump_sel == 2'b11) && (rs_val[1:0] != 2'b00)) begin
         misalign_q <= 1'b1;
      end
   end

   assign misalign_err = misalign_q;
`else
   assign misalign_err = 1'b0;
`endif

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign if_instr  = instr_q;
   assign if_pc4    = pc4_q;
   assign if_valid  = valid_q;
   assign flush     = redir && rst_n;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus randomized run against a
// transaction-level fetch-stream model with a synthetic instruction memory.
module tb_pc_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
   localparam logic ALIGN_EN = 1'b1;
`else
   localparam logic ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  Jump_sel = 2'b00;
   logic [31:0] br_pc4 = 32'h0;
   logic [15:0] br_imm = 16'h0;
   logic [25:0] j_target = 26'h0;
   logic [31:0] rs_val = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata;
   logic [31:0] if_instr;
   logic [31:0] if_pc4;
   logic        if_valid;
   logic        flush;
   logic        misalign_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   pc_fetch #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .Jump_sel(Jump_sel),
      .br_pc4(br_pc4), .br_imm(br_imm), .j_target(j_target), .rs_val(rs_val),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .if_instr(if_instr), .if_pc4(if_pc4),
      .if_valid(if_valid), .flush(flush), .misalign_err(misalign_err)
   );

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; Jump_sel = 2'b01; br_pc4 = 32'h100; br_imm = 16'h1;
      imem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      checks++; if (imem_addr !== RST_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
      checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
      checks++; if (if_pc4 !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", if_pc4); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
      checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
      Jump_sel = 2'b00;
   endtask

   task automatic test_sequential();
      int n;
      stall = 1'b0; Jump_sel = 2'b00; imem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      @(negedge clk);
      while (imem_req !== 1'b1 && n < 5) begin
         @(negedge clk);
         n++;
      end
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL seq_start got req=%b exp=1 (timeout)", imem_req); end
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (imem_addr !== RST_PC + 32'(4 * i)) begin
            failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, RST_PC + 32'(4 * i));
         end
         @(negedge clk);
         checks++;
         if (if_valid !== 1'b1 || if_pc4 !== RST_PC + 32'(4 * (i + 1)) || if_instr !== mem_word(RST_PC + 32'(4 * i))) begin
            failures++; $display("FAIL seq_out%0d got v=%b pc4=%h instr=%h exp v=1 pc4=%h instr=%h", i, if_valid, if_pc4, if_instr,
                                 RST_PC + 32'(4 * (i + 1)), mem_word(RST_PC + 32'(4 * i)));
         end
      end
   endtask

   task automatic test_branch();
      Jump_sel = 2'b01; br_pc4 = 32'h100; br_imm = 16'hFFFE; stall = 1'b0; imem_ready = 1'b1;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL br_flush got=%b exp=1", flush); end
      @(negedge clk);
      Jump_sel = 2'b00;
      #1;
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL br_flush_pulse got=%b exp=0", flush); end
      checks++; if (imem_addr !== 32'hF8) begin failures++; $display("FAIL br_addr got=%h exp=000000f8", imem_addr); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL br_discard got=%b exp=0", if_valid); end
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc4 !== 32'hFC) begin failures++; $display("FAIL br_first got v=%b pc4=%h exp v=1 pc4=000000fc", if_valid, if_pc4); end
   endtask

   task automatic test_jump_wait();
      logic [31:0] old;
      old = imem_addr;
      imem_ready = 1'b0; Jump_sel = 2'b10; j_target = 26'h40; br_pc4 = 32'h1000_0004;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL jw_flush got=%b exp=1", flush); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         Jump_sel = 2'b00;
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== old || if_valid !== 1'b0) begin
            failures++; $display("FAIL jw_hold%0d got req=%b addr=%h v=%b exp req=1 addr=%h v=0", k, imem_req, imem_addr, if_valid, old);
         end
      end
      imem_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (imem_addr !== 32'h1000_0100) begin failures++; $display("FAIL jw_addr got=%h exp=10000100", imem_addr); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL jw_drop got=%b exp=0", if_valid); end
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc4 !== 32'h1000_0104) begin failures++; $display("FAIL jw_first got v=%b pc4=%h exp v=1 pc4=10000104", if_valid, if_pc4); end
   endtask

   task automatic test_stall();
      logic [31:0] a;
      a = imem_addr;
      stall = 1'b1; imem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         Jump_sel = 2'b01; br_pc4 = 32'h2000; br_imm = 16'h0010;
         #1;
         checks++;
         if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_instr !== mem_word(a) || if_pc4 !== a + 32'd4 || flush !== 1'b0) begin
            failures++; $display("FAIL st_hold%0d got req=%b v=%b instr=%h pc4=%h flush=%b exp req=0 v=1 instr=%h pc4=%h flush=0",
                                 k, imem_req, if_valid, if_instr, if_pc4, flush, mem_word(a), a + 32'd4);
         end
      end
      stall = 1'b0; Jump_sel = 2'b00;
      @(negedge clk);
      #1;
      checks++;
      if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== a + 32'd4) begin
         failures++; $display("FAIL st_resume got v=%b req=%b addr=%h exp v=0 req=1 addr=%h", if_valid, imem_req, imem_addr, a + 32'd4);
      end
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc4 !== a + 32'd8) begin failures++; $display("FAIL st_next got v=%b pc4=%h exp v=1 pc4=%h", if_valid, if_pc4, a + 32'd8); end
   endtask

   task automatic test_register();
      Jump_sel = 2'b11; rs_val = 32'h203; stall = 1'b0; imem_ready = 1'b1;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rg_flush got=%b exp=1", flush); end
      @(negedge clk);
      Jump_sel = 2'b00;
      #1;
      checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL rg_addr got=%h exp=00000200", imem_addr); end
      checks++; if (misalign_err !== ALIGN_EN) begin failures++; $display("FAIL rg_misalign got=%b exp=%b", misalign_err, ALIGN_EN); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rg_discard got=%b exp=0", if_valid); end
   endtask

   task automatic test_wrap_reset();
      Jump_sel = 2'b11; rs_val = 32'hFFFF_FFFC; imem_ready = 1'b1;
      @(negedge clk);
      Jump_sel = 2'b00;
      #1;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_top got=%h exp=fffffffc", imem_addr); end
      @(negedge clk);
      #1;
      checks++;
      if (imem_addr !== 32'h0 || if_pc4 !== 32'h0 || if_valid !== 1'b1 || if_instr !== mem_word(32'hFFFF_FFFC)) begin
         failures++; $display("FAIL wr_wrap got addr=%h pc4=%h v=%b instr=%h exp addr=0 pc4=0 v=1 instr=%h",
                              imem_addr, if_pc4, if_valid, if_instr, mem_word(32'hFFFF_FFFC));
      end
      @(negedge clk);
      #1;
      checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL wr_step got=%h exp=00000004", imem_addr); end
      imem_ready = 1'b0; Jump_sel = 2'b01; br_pc4 = 32'h400; br_imm = 16'h4;
      @(negedge clk);
      Jump_sel = 2'b00;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL wr_drain got req=%b addr=%h exp req=1 addr=00000004", imem_req, imem_addr); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== RST_PC || if_valid !== 1'b0 || misalign_err !== 1'b0) begin
         failures++; $display("FAIL wr_rst got req=%b addr=%h v=%b mis=%b exp req=0 addr=%h v=0 mis=0", imem_req, imem_addr, if_valid, misalign_err, RST_PC);
      end
      @(negedge clk);
      imem_ready = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin failures++; $display("FAIL wr_refetch got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RST_PC); end
   endtask

   task automatic test_random();
      logic [31:0] exp_addr, exp_instr, exp_pc4, prev_addr, addr, target;
      logic        exp_valid, exp_mis, stale, prev_wait, req, redir, xfer;
      int          delivered;
      rst_n = 1'b0; Jump_sel = 2'b00; stall = 1'b0; imem_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_addr = RST_PC; exp_valid = 1'b0; exp_instr = 32'h0; exp_pc4 = 32'h0; exp_mis = 1'b0;
      stale = 1'b0; prev_wait = 1'b0; prev_addr = RST_PC; delivered = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         checks++;
         if (if_valid !== exp_valid || (exp_valid && (if_instr !== exp_instr || if_pc4 !== exp_pc4))) begin
            failures++; $display("FAIL rnd_out@%0d got v=%b instr=%h pc4=%h exp v=%b instr=%h pc4=%h",
                                 cyc, if_valid, if_instr, if_pc4, exp_valid, exp_instr, exp_pc4);
         end
         checks++; if (misalign_err !== exp_mis) begin failures++; $display("FAIL rnd_mis@%0d got=%b exp=%b", cyc, misalign_err, exp_mis); end
         stall      = ($urandom_range(0, 3) == 0);
         imem_ready = ($urandom_range(0, 2) != 0);
         Jump_sel   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         br_pc4     = $urandom() & 32'hFFFF_FFFC;
         br_imm     = 16'($urandom());
         j_target   = 26'($urandom());
         rs_val     = ($urandom_range(0, 1) == 0) ? ($urandom() & 32'hFFFF_FFFC) : $urandom();
         #1;
         req   = imem_req;
         addr  = imem_addr;
         redir = (Jump_sel != 2'b00) && !stall;
         xfer  = req && imem_ready;
         checks++; if (flush !== redir) begin failures++; $display("FAIL rnd_flush@%0d got=%b exp=%b", cyc, flush, redir); end
         if (prev_wait) begin
            checks++;
            if (req !== 1'b1 || addr !== prev_addr) begin
               failures++; $display("FAIL rnd_hold@%0d got req=%b addr=%h exp req=1 addr=%h", cyc, req, addr, prev_addr);
            end
         end
         if (xfer && !stale && !redir) begin
            checks++; if (addr !== exp_addr) begin failures++; $display("FAIL rnd_addr@%0d got=%h exp=%h", cyc, addr, exp_addr); end
         end
         case (Jump_sel)
            2'b01:   target = br_pc4 + (32'(signed'(br_imm)) * 32'd4);
            2'b10:   target = (br_pc4 & 32'hF000_0000) | (32'(j_target) * 32'd4);
            default: target = rs_val - 32'(rs_val % 4);
         endcase
         if (xfer) begin
            if (!stale && !redir) begin
               exp_valid = 1'b1; exp_instr = mem_word(addr); exp_pc4 = addr + 32'd4; exp_addr = addr + 32'd4;
               delivered++;
            end else begin
               exp_valid = 1'b0;
            end
            stale = 1'b0;
         end else if (!stall) begin
            exp_valid = 1'b0;
         end
         if (redir) begin
            exp_valid = 1'b0;
            exp_addr = target;
            if (req && !xfer) stale = 1'b1;
            if (ALIGN_EN && Jump_sel == 2'b11 && rs_val[1:0] != 2'b00) exp_mis = 1'b1;
         end
         prev_wait = req && !xfer;
         prev_addr = addr;
      end
      checks++; if (delivered < 100) begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", delivered); end
      Jump_sel = 2'b00; stall = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump_wait();
      test_stall();
      test_register();
      test_wrap_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: one clock; reset is asynchronous and active-low.
REQ-004 stall  input  1  SHALL mean the pipeline is frozen: no redirect accepted, fetched instruction held.
REQ-005 Jump_sel  input  2  SHALL select next PC: 00 PC+4, 01 branch, 10 jump, 11 register.
REQ-006 br_pc4  input  32  SHALL be PC+4 of the resolving branch/jump instruction.
REQ-007 br_imm  input  16  SHALL be the branch immediate; j_target input 26 the jump field; rs_val input 32 the register target.
REQ-008 imem_req  output  1 / imem_addr  output  32 SHALL be the instruction-memory request and address.
REQ-009 imem_ready  input  1 / imem_rdata  input  32 SHALL complete a transfer when imem_req&imem_ready.
REQ-010 if_instr  output  32 / if_pc4  output  32 / if_valid  output  1 SHALL present the fetched instruction, its PC+4, and validity.
REQ-011 flush  output  1 SHALL pulse in the cycle a redirect is accepted; misalign_err output 1 SHALL flag a bad register target.

Function
REQ-012 Redirect SHALL be accepted when Jump_sel!=00 and stall=0; Jump_sel=00 SHALL never redirect.
REQ-013 Targets SHALL be: 01 br_pc4+{{14{br_imm[15]}},br_imm,2'b00}; 10 {br_pc4[31:28],j_target,2'b00}; 11 {rs_val[31:2],2'b00}; sums modulo 2^32.
REQ-014 flush SHALL be combinational, high only in the accept cycle.
REQ-015 FSM states SHALL be IDLE, REQ, DRAIN, HOLD; IDLE is the reset state.
REQ-016 IDLE: imem_req=0; next cycle SHALL go to REQ with imem_addr=pc (redirect in IDLE loads pc first).
REQ-017 REQ: imem_req=1, imem_addr stable until transfer; pc SHALL advance by 4 per transfer, 32'hFFFF_FFFC wrapping to 0.
REQ-018 Transfer in REQ with stall=0, no redirect: if_instr<=imem_rdata, if_pc4<=addr+4, if_valid=1 next cycle; remain REQ (one instruction/cycle sustained).
REQ-019 Transfer in REQ with stall=1: capture as REQ-018, go HOLD; imem_req=0 in HOLD; if_instr/if_pc4/if_valid held.
REQ-020 HOLD: on stall=0 SHALL return to REQ next cycle; if_valid SHALL clear in the first stall=0 cycle unless a new transfer lands.
REQ-021 Redirect in REQ coinciding with transfer: data SHALL be discarded (if_valid=0), pc<=target, stay REQ.
REQ-022 Redirect in REQ without transfer: go DRAIN; imem_req and old imem_addr held; pc<=target.
REQ-023 DRAIN: returned data SHALL be discarded; on transfer go REQ at pending pc; further redirects SHALL overwrite pending pc.
REQ-024 Redirect in HOLD: if_valid cleared, pc<=target, go REQ.
REQ-025 Any accepted redirect SHALL clear if_valid on the next cycle.

Reset
REQ-026 While rst_n=0: pc=RESET_PC, state IDLE, imem_req=0, imem_addr=RESET_PC, if_instr=0, if_pc4=0, if_valid=0, flush=0, misalign_err=0.
REQ-027 Reset asserted mid-transfer SHALL abandon it; first request after release SHALL be RESET_PC.

Configuration
REQ-028 With PC_ALIGN_CHECK_EN defined: Jump_sel=11 accepted with rs_val[1:0]!=0 SHALL set misalign_err sticky until reset; target still uses REQ-013.
REQ-029 Without PC_ALIGN_CHECK_EN: misalign_err SHALL be tied 0 and no check logic built.

Verification
REQ-030 Reset release, imem_ready=1 constant -> addresses 0,4,8,12 on consecutive cycles, if_pc4 4,8,12.
REQ-031 br_pc4=32'h100, br_imm=16'hFFFE, Jump_sel=01, stall=0 -> flush=1 one cycle, next imem_addr=32'hF8, discarded word not valid.
REQ-032 Redirect Jump_sel=10 (j_target=26'h40, br_pc4=32'h1000_0004) while memory waits 3 cycles -> old address held to completion, data dropped, next address 32'h1000_0100.
REQ-033 stall=1 when transfer completes -> imem_req=0, if_instr held stable; stall=0 -> if_valid drops one cycle later, fetch resumes at pc+4.
REQ-034 Jump_sel=11, rs_val=32'h203 -> fetch address 32'h200; misalign_err=1 only with PC_ALIGN_CHECK_EN.
REQ-035 pc=32'hFFFF_FFFC transfer -> next imem_addr=0; rst_n low mid-DRAIN -> next fetch RESET_PC.
